// File: rtl/apb_master.sv
// apb_master: command/response to APB initiator with wait-state, slave-error and timeout handling
module apb_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                busy,
  output logic                tim_psel,
  output logic                tim_penable,
  output logic                tim_pwrite,
  output logic [ADDR_W-1:0]   tim_paddr,
  output logic [DATA_W-1:0]   tim_pwdata,
  output logic [DATA_W/8-1:0] tim_pstrb,
  input  logic [DATA_W-1:0]   tim_prdata,
  input  logic                tim_pready,
  input  logic                tim_pslverr
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_n;
  logic [CW-1:0] wait_cnt;
  logic accept, done, abort;
  assign cmd_ready   = state == IDLE;
  assign busy        = state != IDLE;
  assign tim_psel    = state != IDLE;
  assign tim_penable = state == ACCESS;
  always_comb begin
    accept  = cmd_valid && state == IDLE;
    done    = state == ACCESS && tim_pready;
    abort   = state == ACCESS && !tim_pready && TIMEOUT != 0 && wait_cnt == LAST;
    state_n = accept ? SETUP : state == SETUP ? ACCESS : (done || abort) ? IDLE : state;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      tim_pwrite  <= 1'b0;
      tim_paddr   <= '0;
      tim_pwdata  <= '0;
      tim_pstrb   <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state     <= state_n;
      rsp_valid <= done || abort;
      wait_cnt  <= state == SETUP ? '0 : state == ACCESS ? wait_cnt + CW'(1) : wait_cnt;
      if (accept) begin
        tim_pwrite <= cmd_write;
        tim_paddr  <= cmd_addr;
        tim_pwdata <= cmd_wdata;
        tim_pstrb  <= cmd_write ? cmd_strb : '0;
      end
      if (done) begin
        rsp_rdata   <= tim_pwrite ? '0 : tim_prdata;
        rsp_err     <= tim_pslverr;
        rsp_timeout <= 1'b0;
      end else if (abort) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized scoreboard bench for apb_master
module tb_apb_master;
  localparam int AW = 12, DW = 32, SW = 4, T = 4;
  logic sys_clk = 1'b0, sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;
  logic cmd_valid = 0, cmd_write = 0, cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic rsp_valid, rsp_err, rsp_timeout, busy, tim_psel, tim_penable, tim_pwrite;
  logic [DW-1:0] rsp_rdata, tim_pwdata;
  logic [AW-1:0] tim_paddr;
  logic [SW-1:0] tim_pstrb;
  logic [DW-1:0] tim_prdata = '0;
  logic tim_pready = 0, tim_pslverr = 0;
  logic z_cmd_valid = 0, z_cmd_write = 0, z_cmd_ready;
  logic [AW-1:0] z_cmd_addr = '0;
  logic [DW-1:0] z_cmd_wdata = '0;
  logic [SW-1:0] z_cmd_strb = '0;
  logic z_rsp_valid, z_rsp_err, z_rsp_timeout, z_busy, z_psel, z_penable, z_pwrite;
  logic [DW-1:0] z_rsp_rdata, z_pwdata;
  logic [AW-1:0] z_paddr;
  logic [SW-1:0] z_pstrb;
  logic [DW-1:0] z_prdata = '0;
  logic z_pready = 0, z_pslverr = 0;
  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .busy(busy), .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
    .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
    .tim_prdata(tim_prdata), .tim_pready(tim_pready), .tim_pslverr(tim_pslverr));
  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(0)) u_dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd_valid(z_cmd_valid), .cmd_ready(z_cmd_ready),
    .cmd_write(z_cmd_write), .cmd_addr(z_cmd_addr), .cmd_wdata(z_cmd_wdata), .cmd_strb(z_cmd_strb),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err), .rsp_timeout(z_rsp_timeout),
    .busy(z_busy), .tim_psel(z_psel), .tim_penable(z_penable), .tim_pwrite(z_pwrite),
    .tim_paddr(z_paddr), .tim_pwdata(z_pwdata), .tim_pstrb(z_pstrb),
    .tim_prdata(z_prdata), .tim_pready(z_pready), .tim_pslverr(z_pslverr));
  typedef struct {
    logic w;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [SW-1:0] s;
    logic [DW-1:0] rd;
    logic e, to;
    int cyc;
  } exp_t;
  exp_t q[$];
  int vecs = 0, errs = 0, cyc = 0;
  always @(posedge sys_clk) cyc++;
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  always @(negedge sys_clk) if (!sys_rst) begin
    exp_t x;
    if (cmd_ready) chk("idle_bus", {tim_psel, tim_penable, busy}, 0);
    else chk("busy_bus", {busy, tim_psel}, 2'b11);
    if (tim_psel && q.size() > 0) begin
      chk("paddr", tim_paddr, q[0].a);
      chk("pwrite", tim_pwrite, q[0].w);
      chk("pwdata", tim_pwdata, q[0].wd);
      chk("pstrb", tim_pstrb, q[0].s);
    end
    if (rsp_valid) begin
      if (q.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
      else begin
        x = q.pop_front();
        chk("rsp_cycle", cyc, x.cyc);
        chk("rsp_rdata", rsp_rdata, x.rd);
        chk("rsp_err", rsp_err, x.e);
        chk("rsp_timeout", rsp_timeout, x.to);
      end
    end
  end
  task automatic garbage();
    cmd_valid = 1'($urandom);
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
    cmd_strb  = SW'($urandom);
  endtask
  task automatic txn(logic w, logic [AW-1:0] a, logic [DW-1:0] wd, logic [SW-1:0] s,
                     int ws, logic e, logic [DW-1:0] rd);
    exp_t x;
    int n = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = wd; cmd_strb = s;
    while (!cmd_ready && n < 20) begin @(posedge sys_clk); #1; n++; end
    if (!cmd_ready) begin
      chk("accept_wait", cmd_ready, 1);
      cmd_valid = 0;
      return;
    end
    @(posedge sys_clk); #1;
    x.w = w; x.a = a; x.wd = wd; x.s = w ? s : '0;
    x.to = ws >= T;
    x.e = x.to ? 1'b1 : e;
    x.rd = (x.to || w) ? '0 : rd;
    x.cyc = cyc + (x.to ? 1 + T : 2 + ws);
    q.push_back(x);
    garbage();
    tim_pready = 1'($urandom); tim_pslverr = 1'($urandom); tim_prdata = $urandom;
    @(posedge sys_clk); #1;
    for (int k = 0; k <= ws && k < T; k++) begin
      garbage();
      tim_pready  = k == ws;
      tim_pslverr = k == ws ? e : 1'($urandom);
      tim_prdata  = k == ws ? rd : $urandom;
      @(posedge sys_clk); #1;
    end
    tim_pready = 0; cmd_valid = 0;
  endtask
  task automatic chk_reset_state(string n);
    chk({n, "_ctl"}, {cmd_ready, busy, tim_psel, tim_penable, tim_pwrite, rsp_valid, rsp_err, rsp_timeout}, 8'h80);
    chk({n, "_bus"}, {tim_paddr, tim_pwdata, tim_pstrb}, 0);
    chk({n, "_rdata"}, rsp_rdata, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int bad;
    repeat (3) @(posedge sys_clk);
    #1;
    chk_reset_state("reset");
    sys_rst = 0;
    @(posedge sys_clk); #1;
    txn(1, 12'h004, 32'hA5A5_5A5A, 4'hF, 0, 0, 32'h0);
    txn(0, 12'h010, 32'h0, 4'hF, 2, 0, 32'h1234_5678);
    txn(1, 12'h020, 32'hDEAD_BEEF, 4'h3, 3, 1, 32'h0);
    txn(0, 12'h030, 32'h0, 4'h0, 6, 0, 32'h5555_AAAA);
    txn(1, 12'hFFC, 32'h1, 4'h1, T - 1, 0, 32'h0);
    repeat (2) @(posedge sys_clk);
    #1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h3FF; cmd_wdata = 32'hFFFF_FFFF; cmd_strb = 4'hF;
    @(posedge sys_clk); #1;
    cmd_valid = 0; tim_pready = 0;
    @(posedge sys_clk); #1;
    chk("rst_in_access", {tim_psel, tim_penable}, 2'b11);
    sys_rst = 1;
    @(posedge sys_clk); #1;
    chk_reset_state("rst_mid");
    sys_rst = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    for (int i = 0; i < 40; i++)
      txn(1'($urandom), AW'($urandom), $urandom, SW'($urandom), $urandom_range(0, 6),
          1'($urandom), $urandom);
    z_cmd_valid = 1; z_cmd_write = 0; z_cmd_addr = 12'h020;
    @(posedge sys_clk); #1;
    z_cmd_valid = 0; z_pready = 0;
    @(posedge sys_clk); #1;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      if (z_rsp_valid || !z_psel || !z_penable) bad++;
      z_pslverr = 1'($urandom);
      @(posedge sys_clk); #1;
    end
    chk("t0_no_abort", bad, 0);
    chk("t0_paddr", z_paddr, 12'h020);
    z_pready = 1; z_pslverr = 0; z_prdata = 32'hCAFE_F00D;
    @(posedge sys_clk); #1;
    z_pready = 0;
    chk("t0_rsp_valid", z_rsp_valid, 1);
    chk("t0_rsp", {z_rsp_err, z_rsp_timeout, z_rsp_rdata}, {2'b00, 32'hCAFE_F00D});
    chk("t0_idle", {z_cmd_ready, z_psel, z_penable}, 3'b100);
    repeat (8) @(posedge sys_clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/apb_master.md
# apb_master

APB initiator that drives the timer's APB slave port from a simple command/response interface. It accepts one read or write command at a time and runs the APB SETUP/ACCESS sequence on the `tim_*` bus. It honours slave wait states and `tim_pslverr`, aborts stalled transfers with a configurable timeout, and returns read data and status as a one-cycle response pulse. It sits between the system-side control logic and the timer's APB slave.

## Interface
- `ADDR_W`, 12: APB address width.
- `DATA_W`, 32: data width; must be a multiple of 8.
- `TIMEOUT`, 16: maximum number of ACCESS cycles with `tim_pready`=0 before a transfer is aborted; 0 disables the timeout.

Ports:
- `sys_clk` in 1: single clock; all logic is on the rising edge.
- `sys_rst` in 1: synchronous reset, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when `cmd_valid` and `cmd_ready` are both high at an edge.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in `ADDR_W`: target address.
- `cmd_wdata` in `DATA_W`: write data.
- `cmd_strb` in `DATA_W`/8: write byte strobes.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out `DATA_W`: read data; 0 for writes and for timeouts.
- `rsp_err` out 1: transfer failed (slave error or timeout).
- `rsp_timeout` out 1: failure was caused by a timeout.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `tim_psel`, `tim_penable`, `tim_pwrite` out 1: APB control.
- `tim_paddr` out `ADDR_W`: APB address.
- `tim_pwdata` out `DATA_W`: APB write data.
- `tim_pstrb` out `DATA_W`/8: APB write strobes.
- `tim_prdata` in `DATA_W`: APB read data.
- `tim_pready` in 1: slave ready.
- `tim_pslverr` in 1: slave error.

## Operation
FSM states are IDLE, SETUP and ACCESS.

- **IDLE**
  - `cmd_ready`=1; `cmd_ready` is decoded from the registered state only.
  - On accept, latch write/addr/wdata/strb into `tim_pwrite`, `tim_paddr`, `tim_pwdata`, `tim_pstrb`. For a read, `tim_pstrb` is 0.
  - Set `tim_psel`=1 and go to SETUP.
- **SETUP**
  - `tim_psel`=1, `tim_penable`=0.
  - Unconditionally go to ACCESS, setting `tim_penable`=1.
  - Clear the wait counter.
- **ACCESS** (`tim_psel`=1, `tim_penable`=1)
  - **`tim_pready`=1:** complete the transfer.
    - Clear `tim_psel` and `tim_penable`, and go to IDLE.
    - Pulse `rsp_valid`.
    - `rsp_err`=`tim_pslverr`, `rsp_timeout`=0.
    - `rsp_rdata`=`tim_prdata` for a read, 0 for a write.
  - **`tim_pready`=0, `TIMEOUT`≠0, wait counter = `TIMEOUT`-1:** abort the transfer.
    - Clear `tim_psel` and `tim_penable`, and go to IDLE.
    - Pulse `rsp_valid` with `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - **Otherwise:** increment the wait counter (width clog2(`TIMEOUT`+1), minimum 1) and stay in ACCESS.
- `tim_pslverr` and `tim_prdata` are ignored unless `tim_pready`=1 in ACCESS.
- `tim_paddr`, `tim_pwrite`, `tim_pwdata` and `tim_pstrb` are stable from SETUP to the end of ACCESS. Between transfers they hold their last values.
- `cmd_*` inputs are ignored while `cmd_ready`=0; no queuing. A `cmd_valid` held high is accepted on the first IDLE cycle.
- Reset: outputs are cleared at the next `sys_clk` edge with `sys_rst`=1. Any in-flight transfer is dropped without a response.

## Timing
- All outputs are registered.
- Reset values: every output is 0 except `cmd_ready`=1 (IDLE).
- Zero-wait transfer:
  - Accept at edge E0.
  - SETUP in cycle E0–E1.
  - ACCESS in cycle E1–E2; `tim_pready` is sampled at E2.
  - `rsp_valid` is high in cycle E2–E3, and `cmd_ready`=1 in the same cycle.
  - Next accept no earlier than E3, giving 3 cycles per transfer.
- Each wait state adds one cycle.
- Timeout: `rsp_valid` is asserted exactly `TIMEOUT` ACCESS cycles after ACCESS entry.
- `rsp_valid` is high for exactly one cycle. `rsp_rdata`, `rsp_err` and `rsp_timeout` hold their values until the next response.
- `tim_psel` and `tim_penable` are never 1 in IDLE; `tim_penable` is never 1 in SETUP.

## Test plan
- Write, addr 0x004, data 0xA5A5_5A5A, strb 0xF, slave `tim_pready`=1 immediately -> SETUP one cycle with psel=1/penable=0, ACCESS one cycle, `rsp_valid` pulse, `rsp_err`=0, `rsp_rdata`=0, `cmd_ready` back 3 cycles after accept.
- Read, addr 0x010, slave inserts 2 wait states then returns 0x1234_5678 -> ACCESS lasts 3 cycles with addr/pwrite stable and `tim_pstrb`=0; `rsp_rdata`=0x1234_5678, `rsp_err`=0.
- Write with `tim_pslverr`=1 at the completing cycle (`tim_pslverr`=1 during earlier wait cycles is ignored) -> `rsp_err`=1, `rsp_timeout`=0.
- `TIMEOUT`=4, `tim_pready` held 0 -> abort after 4 ACCESS cycles, psel/penable drop, `rsp_valid`=1, `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0. Rerun with `TIMEOUT`=0 and 50 stall cycles -> no abort.
- `sys_rst`=1 during ACCESS -> next edge all outputs 0 except `cmd_ready`=1, no `rsp_valid`. A fresh command then completes normally.
- `cmd_valid` held high with changing `cmd_addr` while busy -> only the address present on the IDLE accept edge appears on `tim_paddr`; back-to-back commands are spaced 3 cycles apart.
